alu_chain_ctrl: RTL and testbench
=================================

Name: alu_chain_ctrl

Overview:
- Initiator-side sequencer that drives the team's 8-bit combinational ALU.
- Executes NBYTES-wide operations, one byte per cycle, LSB first, chaining the carry between bytes.
- Accepts requests on a valid/ready interface and returns the wide result plus final carry on a valid/ready response interface.
- Sits between the datapath control and a single shared 8-bit ALU instance.

Parameters:
NBYTES, 2, operand width in bytes (>=1); operand/result width is 8*NBYTES

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_op  input  4  {s[2:0], cin} function code, encoding below
req_a  input  8*NBYTES  operand A
req_b  input  8*NBYTES  operand B
alu_a  output  8  ALU operand A byte
alu_b  output  8  ALU operand B byte
alu_s  output  3  ALU function select
alu_cin  output  1  ALU carry-in / logic sub-select
alu_g  input  8  ALU result byte (combinational from alu_* outputs)
alu_cout  input  1  ALU carry-out
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_g  output  8*NBYTES  result
rsp_cout  output  1  carry-out of the most significant byte

Behaviour:
- ALU encoding, used unchanged on every byte:
  - s[2]=1 selects logic; {s[0],cin}: 00 AND, 01 OR, 10 XOR, 11 NOT A; cout=0.
  - s[2]=0 selects arithmetic: G = A + T + cin, with s[1:0] choosing T: 00 zero, 01 B, 10 ~B, 11 all-ones; cout = bit 8 of the sum.
- Common codes:
  - ADD 0010
  - ADC-less SUB 0101
  - INC 0001
  - DEC 0110
  - AND 1000, OR 1001, XOR 1010, NOT 1011
- Reset values (async, rst_n=0):
  - state=IDLE; req_ready=1.
  - rsp_valid=0, rsp_g=0, rsp_cout=0.
  - alu_a=0, alu_b=0, alu_s=0, alu_cin=0.
  - Byte index=0; internal operand/carry registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_a, req_b, req_op; byte index=0; drive byte 0 registers; go to RUN.
- RUN, byte index k in 0..NBYTES-1:
  - Registered outputs present byte k: alu_a=A[8k+7:8k], alu_b=B[8k+7:8k], alu_s=op[3:1].
  - alu_cin for k=0: op[0].
  - alu_cin for k>0: latched alu_cout of byte k-1 if op[3]=0 (arithmetic); op[0] if op[3]=1 (logic sub-select must stay constant).
  - At the end of each RUN cycle: capture alu_g into rsp_g[8k+7:8k] and alu_cout into the carry register.
  - If k=NBYTES-1: rsp_cout=alu_cout, rsp_valid=1, go to DONE.
  - Otherwise: k=k+1 and present the next byte.
  - req_ready=0 throughout.
- Latency: rsp_valid rises exactly NBYTES cycles after the accepting edge.
- DONE:
  - rsp_valid=1; rsp_g and rsp_cout held stable while rsp_ready=0; req_ready=0.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake (no same-cycle turnaround).
- In IDLE and DONE, alu_s and alu_cin are driven 0; alu_a and alu_b hold their last value.
- rsp_g is not cleared between operations; it is valid only while rsp_valid=1.
- Reset mid-operation: the operation is discarded, all outputs return to reset values, and no response is produced.
- Inputs req_a, req_b and req_op are don't-care outside the accepting cycle.
- Unsigned wrap-around per byte; the final carry is not fed back.

Test Plan:
- ADD req_op=0010, A=0x12FF, B=0x0001 -> after 2 cycles rsp_g=0x1300, rsp_cout=0; alu_cin=1 observed on byte 1 (carry crossing the byte boundary).
- SUB req_op=0101, A=0x1000, B=0x0001 -> rsp_g=0x0FFF, rsp_cout=1; also A=0x0000, B=0x0001 -> rsp_g=0xFFFF, rsp_cout=0 (borrow).
- DEC req_op=0110, A=0x0000 -> rsp_g=0xFFFF, rsp_cout=0; INC req_op=0001, A=0xFFFF -> rsp_g=0x0000, rsp_cout=1.
- XOR req_op=1010, A=0xA5F0, B=0x0FF0 -> rsp_g=0xAA00; NOT req_op=1011, A=0x00FF -> rsp_g=0xFF00; alu_cin=0 on XOR byte 1 and alu_cin=1 on NOT byte 1, rsp_cout=0 for both.
- Backpressure: hold rsp_ready=0 for 5 cycles while req_valid=1 with a new request -> rsp_g and rsp_valid stable, req_ready=0; new request accepted the cycle after the rsp handshake; its result is correct.
- Pulse rst_n low during byte 1 of an ADD -> outputs immediately at reset values, rsp_valid never rises for that op; the next request ADD 0x0001+0x0001 returns 0x0002.

Source files
------------

// File: rtl/alu_chain_ctrl.sv
// Byte-serial sequencer for a shared 8-bit ALU: runs NBYTES-wide ops LSB first,
// chaining carry between bytes, with valid/ready request and response sides.
module alu_chain_ctrl #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [2:0]            alu_s,
  output logic                  alu_cin,
  input  logic [7:0]            alu_g,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_g,
  output logic                  rsp_cout
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q;
  logic [IW-1:0]       idx_q;
  logic [8*NBYTES-1:0] a_q, b_q;
  logic [3:0]          op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_g     <= '0;
      rsp_cout  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      alu_cin   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q       <= req_a;
            b_q       <= req_b;
            op_q      <= req_op;
            idx_q     <= '0;
            alu_a     <= req_a[7:0];
            alu_b     <= req_b[7:0];
            alu_s     <= req_op[3:1];
            alu_cin   <= req_op[0];
            req_ready <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          rsp_g[8*idx_q +: 8] <= alu_g;
          if (idx_q == LAST) begin
            rsp_cout  <= alu_cout;
            rsp_valid <= 1'b1;
            alu_s     <= '0;
            alu_cin   <= 1'b0;
            state_q   <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
            alu_a <= a_q[8*(idx_q + 1'b1) +: 8];
            alu_b <= b_q[8*(idx_q + 1'b1) +: 8];
            // Logic ops reuse cin as a function sub-select, so it must not chain.
            alu_cin <= op_q[3] ? op_q[0] : alu_cout;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_chain_ctrl.sv
// Directed bench for alu_chain_ctrl (NBYTES=2) with a behavioural 8-bit ALU.
module tb_alu_chain_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [7:0]  alu_a, alu_b, alu_g;
  logic [2:0]  alu_s;
  logic        alu_cin, alu_cout;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_g;
  logic        rsp_cout;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_chain_ctrl #(.NBYTES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_g(alu_g), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_g(rsp_g), .rsp_cout(rsp_cout)
  );

  // Reference ALU
  always_comb begin
    logic [7:0] t;
    logic [8:0] sum;
    alu_g    = '0;
    alu_cout = 1'b0;
    t        = '0;
    sum      = '0;
    if (alu_s[2]) begin
      case ({alu_s[0], alu_cin})
        2'b00:   alu_g = alu_a & alu_b;
        2'b01:   alu_g = alu_a | alu_b;
        2'b10:   alu_g = alu_a ^ alu_b;
        default: alu_g = ~alu_a;
      endcase
    end else begin
      case (alu_s[1:0])
        2'b00:   t = 8'h00;
        2'b01:   t = alu_b;
        2'b10:   t = ~alu_b;
        default: t = 8'hFF;
      endcase
      sum      = {1'b0, alu_a} + {1'b0, t} + {8'h00, alu_cin};
      alu_g    = sum[7:0];
      alu_cout = sum[8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction: request, two byte cycles, response, handshake.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] eg, input logic ec,
                        input logic cin1);
    @(negedge clk);
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_a = 16'hDEAD; req_b = 16'hBEEF; req_op = 4'hF;
    chk({tag, ".b0_alu_a"}, {24'd0, alu_a}, {24'd0, a[7:0]});
    chk({tag, ".b0_alu_cin"}, {31'd0, alu_cin}, {31'd0, op[0]});
    chk({tag, ".b0_ready"}, {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk({tag, ".b1_alu_a"}, {24'd0, alu_a}, {24'd0, a[15:8]});
    chk({tag, ".b1_alu_s"}, {29'd0, alu_s}, {29'd0, op[3:1]});
    chk({tag, ".b1_alu_cin"}, {31'd0, alu_cin}, {31'd0, cin1});
    chk({tag, ".b1_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, ".rsp_g"}, {16'd0, rsp_g}, {16'd0, eg});
    chk({tag, ".rsp_cout"}, {31'd0, rsp_cout}, {31'd0, ec});
    chk({tag, ".done_alu_s"}, {28'd0, alu_s, alu_cin}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".post_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".post_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    #12;
    chk("reset.outs", {req_ready, rsp_valid, rsp_cout, alu_s, alu_cin}, 32'h40);
    chk("reset.alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
    chk("reset.rsp_g", {16'd0, rsp_g}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add",   4'b0010, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b1);
    run_op("sub",   4'b0101, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0);
    run_op("sub0",  4'b0101, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    run_op("dec",   4'b0110, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    run_op("inc",   4'b0001, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1);
    run_op("xor",   4'b1010, 16'hA5F0, 16'h0FF0, 16'hAA00, 1'b0, 1'b0);
    run_op("not",   4'b1011, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b1);

    // Backpressure: ADD 0x0001+0x0002, then hold response while a new XOR waits.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b0010; req_a = 16'h0001; req_b = 16'h0002;
    @(negedge clk);
    req_op = 4'b1010; req_a = 16'hFFFF; req_b = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp.rsp_g", {16'd0, rsp_g}, 32'h0003);
      chk("bp.ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp.hs_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp.hs_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp.accepted", {31'd0, req_ready}, 32'd0);
    chk("bp.b0_alu_a", {24'd0, alu_a}, 32'hFF);
    @(negedge clk);
    @(negedge clk);
    chk("bp.new_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp.new_rsp_g", {16'd0, rsp_g}, 32'hEDCB);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during byte 1 of an ADD.
    req_valid = 1'b1; req_op = 4'b0010; req_a = 16'h3456; req_b = 16'h1111;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst.b1_alu_a", {24'd0, alu_a}, 32'h34);
    rst_n = 1'b0;
    #1;
    chk("rst.outs", {req_ready, rsp_valid, rsp_cout, alu_s, alu_cin}, 32'h40);
    chk("rst.alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
    chk("rst.rsp_g", {16'd0, rsp_g}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst.no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    run_op("add11", 4'b0010, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
